col_drain_buf: RTL

Parametrised successor to the per-column output controller of the systolic array. Captures one result per PE row into a multi-bank tile buffer, so the array can fill tile k+1 while tile k drains. Drains each completed tile to the top level over a valid/ready stream, tagging each beat with its row index and a last flag. Detects dropped and duplicate writes instead of silently corrupting data.

---
 rtl/systola_out_pkg.sv | 23 ++
 rtl/col_bank_ctrl.sv | 102 ++++++++++
 rtl/col_drain_buf.sv | 130 +++++++++++++
 3 files changed

// File: rtl/systola_out_pkg.sv
// Shared types and helpers for the systolic-array column drain buffer.
package systola_out_pkg;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_e;

  // Increment with wrap n-1 -> 0.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

  function automatic int unsigned row_start(input int unsigned rows, input bit rev);
    return rev ? rows - 1 : 0;
  endfunction

  function automatic int unsigned row_end(input int unsigned rows, input bit rev);
    return rev ? 0 : rows - 1;
  endfunction

endpackage

// File: rtl/col_bank_ctrl.sv
// Bank bookkeeping: per-bank state, write/read pointers, full-bank count,
// tile_done pulse and sticky error flags.
module col_bank_ctrl
  import systola_out_pkg::*;
#(
  parameter int unsigned NBANK = 2,
  parameter int unsigned BW    = $clog2(NBANK + 1),
  parameter int unsigned PW    = (NBANK > 1) ? $clog2(NBANK) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  input  logic          err_clr,
  input  logic          wr_en,
  input  logic          wr_complete,
  input  logic          wr_drop,
  input  logic          wr_dup,
  input  logic          rd_last,
  output logic [PW-1:0] wptr,
  output logic [PW-1:0] rptr,
  output logic          wr_full_c,
  output logic          rd_full_c,
  output logic          tile_done,
  output logic [BW-1:0] full_banks,
  output logic          overflow,
  output logic          dup_err
);

  bank_state_e   bank_q [NBANK];
  bank_state_e   bank_d [NBANK];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          tile_done_q, tile_done_d;
  logic [BW-1:0] full_banks_q, full_banks_d;
  logic          overflow_q, overflow_d;
  logic          dup_err_q, dup_err_d;

  assign wr_full_c  = (bank_q[wptr_q] == FULL);
  assign rd_full_c  = (bank_q[rptr_q] == FULL);
  assign wptr       = wptr_q;
  assign rptr       = rptr_q;
  assign tile_done  = tile_done_q;
  assign full_banks = full_banks_q;
  assign overflow   = overflow_q;
  assign dup_err    = dup_err_q;

  // Completion and drain-last always target different banks, so both apply.
  always_comb begin
    bank_d       = bank_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    tile_done_d  = 1'b0;
    full_banks_d = '0;

    if (wr_en && bank_q[wptr_q] == FREE) bank_d[wptr_q] = FILLING;
    if (wr_complete) begin
      bank_d[wptr_q] = FULL;
      wptr_d         = PW'(wrap_inc(32'(wptr_q), NBANK));
    end
    if (rd_last) begin
      bank_d[rptr_q] = FREE;
      rptr_d         = PW'(wrap_inc(32'(rptr_q), NBANK));
      tile_done_d    = 1'b1;
    end

    if (flush) begin
      for (int unsigned b = 0; b < NBANK; b++) bank_d[b] = FREE;
      wptr_d      = '0;
      rptr_d      = '0;
      tile_done_d = 1'b0;
    end

    for (int unsigned b = 0; b < NBANK; b++) begin
      if (bank_d[b] == FULL) full_banks_d = full_banks_d + BW'(1);
    end

    // A new error in the err_clr cycle wins.
    overflow_d = (overflow_q && !err_clr) || (wr_drop && !flush);
    dup_err_d  = (dup_err_q  && !err_clr) || (wr_dup  && !flush);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned b = 0; b < NBANK; b++) bank_q[b] <= FREE;
      wptr_q       <= '0;
      rptr_q       <= '0;
      tile_done_q  <= 1'b0;
      full_banks_q <= '0;
      overflow_q   <= 1'b0;
      dup_err_q    <= 1'b0;
    end else begin
      bank_q       <= bank_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      tile_done_q  <= tile_done_d;
      full_banks_q <= full_banks_d;
      overflow_q   <= overflow_d;
      dup_err_q    <= dup_err_d;
    end
  end

endmodule

// File: rtl/col_drain_buf.sv
// Per-column output buffer: captures one result per PE row into a multi-bank
// tile buffer and drains completed tiles over a valid/ready stream.
module col_drain_buf
  import systola_out_pkg::*;
#(
  parameter int unsigned ROWS      = 8,
  parameter int unsigned OUTWIDTH  = 32,
  parameter int unsigned NBANK     = 2,
  parameter int unsigned REV_ORDER = 0,
  parameter int unsigned RW        = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int unsigned BW        = $clog2(NBANK + 1)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [OUTWIDTH-1:0] in_r [0:ROWS-1],
  input  logic [ROWS-1:0]     in_v,
  input  logic                flush,
  input  logic                err_clr,
  output logic [OUTWIDTH-1:0] out_data,
  output logic [RW-1:0]       out_row,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                tile_done,
  output logic [BW-1:0]       full_banks,
  output logic                overflow,
  output logic                dup_err
);

  localparam int unsigned   PW        = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam logic [RW-1:0] START_ROW = RW'(row_start(ROWS, REV_ORDER != 0));
  localparam logic [RW-1:0] END_ROW   = RW'(row_end(ROWS, REV_ORDER != 0));

  logic [OUTWIDTH-1:0] data_q [NBANK][ROWS];
  logic [OUTWIDTH-1:0] data_d [NBANK][ROWS];
  logic [ROWS-1:0]     mask_q [NBANK];
  logic [ROWS-1:0]     mask_d [NBANK];
  logic [RW-1:0]       rowptr_q, rowptr_d;

  logic [PW-1:0]   wptr, rptr;
  logic            wr_full_c, rd_full_c;
  logic            wr_act, wr_en, wr_drop, wr_dup, wr_complete;
  logic            fire, at_end, rd_last;
  logic [ROWS-1:0] new_mask;

  col_bank_ctrl #(
    .NBANK (NBANK),
    .BW    (BW),
    .PW    (PW)
  ) u_ctrl (
    .clk         (clk),
    .rstn        (rstn),
    .flush       (flush),
    .err_clr     (err_clr),
    .wr_en       (wr_en),
    .wr_complete (wr_complete),
    .wr_drop     (wr_drop),
    .wr_dup      (wr_dup),
    .rd_last     (rd_last),
    .wptr        (wptr),
    .rptr        (rptr),
    .wr_full_c   (wr_full_c),
    .rd_full_c   (rd_full_c),
    .tile_done   (tile_done),
    .full_banks  (full_banks),
    .overflow    (overflow),
    .dup_err     (dup_err)
  );

  // Write side: accept into the current write bank unless it is still FULL.
  assign wr_act      = (|in_v) && !flush;
  assign wr_en       = wr_act && !wr_full_c;
  assign wr_drop     = wr_act && wr_full_c;
  assign new_mask    = mask_q[wptr] | in_v;
  assign wr_dup      = wr_en && (|(mask_q[wptr] & in_v));
  assign wr_complete = wr_en && (new_mask == {ROWS{1'b1}});

  assign out_valid = rd_full_c;
  assign at_end    = (rowptr_q == END_ROW);
  assign fire      = out_valid && out_ready && !flush;
  assign rd_last   = fire && at_end;
  assign out_row   = rowptr_q;
  assign out_last  = out_valid && at_end;
  assign out_data  = out_valid ? data_q[rptr][rowptr_q] : '0;

  always_comb begin
    data_d   = data_q;
    mask_d   = mask_q;
    rowptr_d = rowptr_q;

    if (wr_en) begin
      for (int unsigned i = 0; i < ROWS; i++) begin
        if (in_v[i]) data_d[wptr][i] = in_r[i];
      end
      mask_d[wptr] = new_mask;
    end

    if (fire) begin
      if (at_end) begin
        rowptr_d     = START_ROW;
        mask_d[rptr] = '0;
      end else if (REV_ORDER != 0) begin
        rowptr_d = rowptr_q - RW'(1);
      end else begin
        rowptr_d = rowptr_q + RW'(1);
      end
    end

    if (flush) begin
      for (int unsigned b = 0; b < NBANK; b++) mask_d[b] = '0;
      rowptr_d = START_ROW;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned b = 0; b < NBANK; b++) mask_q[b] <= '0;
      rowptr_q <= START_ROW;
    end else begin
      mask_q   <= mask_d;
      rowptr_q <= rowptr_d;
    end
  end

  // Payload storage needs no reset; it is only visible behind a FULL bank.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

endmodule
